// File: rtl/cla_nibble_seq_ctrl.sv
// cla_nibble_seq_ctrl: multi-cycle add/subtract controller that time-shares a
// single 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand request valid
//   in_ready   controller can accept an operation (IDLE and not in reset)
//   a, b       WIDTH-bit operands, sampled only at the accept edge
//   sub        0 = a+b, 1 = a-b
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     WIDTH-bit sum/difference (modulo 2^WIDTH)
//   cout       final carry out (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       result == 0

// 4-bit carry-lookahead adder slice.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c4
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Each carry is expanded directly from generate/propagate terms.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s  = w_p ^ w_c[3:0];
  assign c4 = w_c[4];
endmodule

module cla_nibble_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("cla_nibble_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_beff_msb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0]       w_s;
  logic             w_c4;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH+3:0] w_res_cat;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Subtract is a + ~b + 1; the +1 enters through the initial carry.
  assign w_b_eff = sub ? ~b : b;

  cla_4bit u_cla (
    .a   (r_a[3:0]),
    .b   (r_b[3:0]),
    .cin (r_carry),
    .s   (w_s),
    .c4  (w_c4)
  );

  // New sum nibble enters from the MSB side so the LSB nibble ends up lowest.
  assign w_res_cat  = {w_s, r_res};
  assign w_res_next = w_res_cat[WIDTH+3:4];
  assign w_last     = (r_cnt == CNT_W'(NIB - 1));

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign out_valid = r_out_valid;
  assign result    = r_res;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

  // Controller FSM with datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_a_msb     <= 1'b0;
      r_beff_msb  <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= w_b_eff;
            r_carry    <= sub;
            r_a_msb    <= a[WIDTH-1];
            r_beff_msb <= w_b_eff[WIDTH-1];
            r_cnt      <= '0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_c4;
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_cout      <= w_c4;
            r_zero      <= (w_res_next == '0);
            // Same-sign operands producing a different-sign result overflowed.
            r_ovf       <= (r_a_msb == r_beff_msb) & (w_s[3] != r_a_msb);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/cla_nibble_seq_ctrl.md
Name: cla_nibble_seq_ctrl

Overview:
- Multi-cycle add/subtract controller that time-shares one cla_4bit slice to process WIDTH-bit operands one nibble per cycle, LSB nibble first.
- Owns the operand/result shift registers, the inter-nibble carry register and the FSM.
- Uses valid/ready handshakes on the input and result sides.
- Sits between the ALU issue logic and the register writeback. It is the area-cheap alternative to a full-width lookahead adder.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; violation is an elaboration error.
- NIB, WIDTH/4 (derived, localparam), number of nibble passes per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference.
- cout  output  1  final carry out (for sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, result=0, cout=0, ovf=0, zero=0, out_valid=0, carry/counter/shift regs=0.
  - in_ready = (state==IDLE) & ~rst, so it reads 1 in the first cycle after reset deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge T, latch:
    - A_sh = a
    - B_sh = sub ? ~b : b
    - carry = sub
    - a_msb = a[WIDTH-1]
    - beff_msb = (sub ? ~b : b)[WIDTH-1]
    - cnt = 0
  - Then go to RUN.
- RUN:
  - One internal cla_4bit instance computes A_sh[3:0] + B_sh[3:0] + carry each cycle.
  - At each edge:
    - Shift the sum nibble into the result register from the MSB side (res <= {S, res[WIDTH-1:4]}).
    - Shift A_sh and B_sh right by 4.
    - carry <= C4.
    - cnt <= cnt+1.
  - On the edge where cnt==NIB-1, go to DONE and set:
    - out_valid=1
    - cout=C4
    - zero=(final res==0)
    - ovf = (a_msb==beff_msb) & (S[3]!=a_msb)
  - in_ready=0 and in_valid is ignored throughout RUN.
- DONE:
  - out_valid=1. result, cout, ovf and zero are held stable until out_ready is seen high.
  - On out_valid & out_ready, go to IDLE and clear out_valid at that edge. result and the flags keep their last values.
  - in_ready=0 in DONE; no back-to-back overlap.
- Latency:
  - Input handshake at edge T means out_valid is high from edge T+NIB onward (T+4 for WIDTH=16).
  - With out_ready held high, the next op can be accepted at edge T+NIB+2, giving a throughput of NIB+2 cycles per op.
- Block P/G outputs of the slice are unused.
- Arithmetic is modulo 2^WIDTH. The subtract path uses the ~b + 1 injected via the initial carry.
- Reset in RUN or DONE aborts the operation with no result delivered: return to IDLE with all reset values above.
- Reset dominates a simultaneous handshake.
- out_ready while out_valid=0 has no effect.
- Inputs a, b and sub are sampled only at the accept edge; later changes are ignored.

Test Plan:
- Basic add: a=0x1234, b=0x0FCD, sub=0, out_ready=1.
  - Response: result=0x2201, cout=0, ovf=0, zero=0.
  - Latency: out_valid rises exactly 4 cycles after the accept edge.
- Wrap-around: a=0xFFFF, b=0x0001, add.
  - Response: result=0x0000, cout=1, zero=1, ovf=0.
- Signed overflow:
  - Add 0x7FFF+0x0001 gives result=0x8000, ovf=1, cout=0.
  - Sub 0x8000-0x0001 gives result=0x7FFF, ovf=1, cout=1.
  - Sub 0x0003-0x0005 gives result=0xFFFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and pulse in_valid with new operands during that window.
  - result and flags stay constant; in_ready stays 0 and the new request is not accepted.
  - After out_ready=1 for one edge: out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-op: assert rst for 1 cycle after 2 RUN edges.
  - Next cycle: out_valid=0, in_ready=1, result=0, flags=0.
  - The aborted op never produces out_valid.
- Back-to-back stream: 3 ops with in_valid held high and out_ready=1.
  - Accepts occur at 6-cycle spacing and results appear in order with correct values.
